// File: rtl/oled_spi_tx_queue_if.sv
// oled_spi_tx_queue_if: producer-side queue handshake, status flags and the
// SSD1306 4-wire SPI pins of oled_spi_tx_queue, bundled as one interface.
// master = producer/board side, slave = the queue itself.
interface oled_spi_tx_queue_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  // producer handshake
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_dc;
  logic              push_last;

  // queue status
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              busy;

  // OLED pins
  logic              oled_csn;
  logic              oled_dc;
  logic              oled_clk;
  logic              oled_mosi;

  modport master (
    output push, push_data, push_dc, push_last,
    input  full, empty, level, overflow, busy,
    input  oled_csn, oled_dc, oled_clk, oled_mosi
  );

  modport slave (
    input  push, push_data, push_dc, push_last,
    output full, empty, level, overflow, busy,
    output oled_csn, oled_dc, oled_clk, oled_mosi
  );
endinterface

// File: rtl/oled_spi_tx_queue.sv
// oled_spi_tx_queue: FIFO of {last, dc, word} entries serialised onto an
// SSD1306 4-wire SPI bus (CPOL=0, CPHA=0, MSB first). CS stays low across
// words until a last-flagged word completes, followed by a CS-high gap.
// Optional build macro OLED_SPI_TX_STATS_EN adds tx_count / drop_count.
module oled_spi_tx_queue #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic                 clk_in,
  input  logic                 reset,
  oled_spi_tx_queue_if.slave   bus
`ifdef OLED_SPI_TX_STATS_EN
  ,
  output logic [15:0]          tx_count,
  output logic [7:0]           drop_count
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENT_W   = DATA_W + 2;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int HALF_W  = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic              w_push_ok;
  logic              w_drop;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level_next;
  logic [ENT_W-1:0]  w_head;

  // serialiser state
  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] w_half_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_last;
  logic              w_last_next;
  logic              r_csn;
  logic              w_csn_next;
  logic              r_sck;
  logic              w_sck_next;
  logic              r_mosi;
  logic              w_mosi_next;
  logic              r_dc;
  logic              w_dc_next;

  // Head entry is read combinationally so it can be loaded in the pop cycle.
  assign w_head    = r_mem[r_rd_ptr];
  // full is registered, so a push seen while full is dropped even if the
  // serialiser pops in the same cycle.
  assign w_push_ok = bus.push & ~r_full;
  assign w_drop    = bus.push & r_full;

  // Level update: push and pop in one cycle cancel out.
  always_comb begin
    w_level_next = r_level;
    if (w_push_ok && !w_pop) begin
      w_level_next = r_level + LVL_W'(1);
    end else if (!w_push_ok && w_pop) begin
      w_level_next = r_level - LVL_W'(1);
    end
  end

  // FIFO write port (storage is not reset; only pointers and flags are).
  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {bus.push_last, bus.push_dc, bus.push_data};
    end
  end

  // FIFO pointers, level, flags and the sticky overflow bit.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_W'(DEPTH));
      r_empty <= (w_level_next == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Serialiser next-state and next-output logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_half_next  = r_half;
    w_shift_next = r_shift;
    w_last_next  = r_last;
    w_csn_next   = r_csn;
    w_sck_next   = r_sck;
    w_mosi_next  = r_mosi;
    w_dc_next    = r_dc;
    w_pop        = 1'b0;

    case (r_state)
      S_IDLE, S_HOLD: begin
        w_csn_next = (r_state == S_IDLE) ? 1'b1 : 1'b0;
        w_sck_next = 1'b0;
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head[DATA_W-1:0];
          w_mosi_next  = w_head[DATA_W-1];
          w_dc_next    = w_head[DATA_W];
          w_last_next  = w_head[DATA_W+1];
          w_csn_next   = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_SETUP;
        end
      end

      S_SETUP: begin
        // MOSI already holds the MSB; give it a half period before SCK rises.
        if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
          w_cnt_next   = '0;
          w_half_next  = '0;
          w_sck_next   = 1'b1;
          w_state_next = S_SHIFT;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        // r_half counts SCK half periods; even halves are SCK high.
        if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
          w_cnt_next = '0;
          if (r_half == HALF_W'(2 * DATA_W - 1)) begin
            // Final low half period done: word complete, SCK already low.
            w_state_next = S_NEXT;
            if (r_last) begin
              w_csn_next = 1'b1;
            end
          end else begin
            w_half_next = r_half + HALF_W'(1);
            w_sck_next  = ~r_sck;
            // Falling edge: present the next bit, except after the last bit.
            if (r_sck && (r_half != HALF_W'(2 * DATA_W - 2))) begin
              w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
              w_mosi_next  = r_shift[DATA_W-2];
            end
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_NEXT: begin
        w_sck_next = 1'b0;
        if (r_last) begin
          w_csn_next   = 1'b1;
          w_mosi_next  = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_GAP;
        end else if (!r_empty) begin
          // Chain the next word without releasing CS.
          w_pop        = 1'b1;
          w_shift_next = w_head[DATA_W-1:0];
          w_mosi_next  = w_head[DATA_W-1];
          w_dc_next    = w_head[DATA_W];
          w_last_next  = w_head[DATA_W+1];
          w_csn_next   = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_SETUP;
        end else begin
          w_state_next = S_HOLD;
        end
      end

      S_GAP: begin
        w_csn_next = 1'b1;
        w_sck_next = 1'b0;
        if (r_cnt == CNT_W'(CS_GAP - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_csn_next   = 1'b1;
        w_sck_next   = 1'b0;
      end
    endcase
  end

  // Serialiser state and pin registers; reset aborts any word in flight.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_csn   <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_dc    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_half  <= w_half_next;
      r_shift <= w_shift_next;
      r_last  <= w_last_next;
      r_csn   <= w_csn_next;
      r_sck   <= w_sck_next;
      r_mosi  <= w_mosi_next;
      r_dc    <= w_dc_next;
    end
  end

  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.oled_csn  = r_csn;
  assign bus.oled_dc   = r_dc;
  assign bus.oled_clk  = r_sck;
  assign bus.oled_mosi = r_mosi;

`ifdef OLED_SPI_TX_STATS_EN
  logic [15:0] r_tx_count;
  logic [7:0]  r_drop_count;

  // Completed-word counter (wraps) and dropped-push counter (saturates).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (r_state == S_NEXT) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_oled_spi_tx_queue.sv
// Bench for oled_spi_tx_queue: an SPI pin monitor rebuilds {last, dc, word}
// records from the bus (last = CS rose after the word) and each scenario
// compares them against the words it queued. Build with
// +define+OLED_SPI_TX_STATS_EN to also cover tx_count / drop_count.
`timescale 1ns/1ps
module tb_oled_spi_tx_queue;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  // CS low time of one stand-alone word: setup half period + 2*DATA_W halves
  localparam int WORD_CYC = CLK_DIV + 2 * DATA_W * CLK_DIV;

  typedef logic [DATA_W+1:0] ent_t;  // {last, dc, data}

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  oled_spi_tx_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef OLED_SPI_TX_STATS_EN
  logic [15:0] tx_count;
  logic [7:0]  drop_count;
`endif

  oled_spi_tx_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .bus       (bus)
`ifdef OLED_SPI_TX_STATS_EN
    ,
    .tx_count  (tx_count),
    .drop_count(drop_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  ent_t rx_q[$];
  ent_t exp_q[$];

  // ---------------- SPI monitor (samples on the falling clk edge) --------
  logic [DATA_W-1:0] mon_sh = '0;
  int                mon_bits = 0;
  logic              mon_dc = 1'b0;
  logic              prev_sck = 1'b0;
  logic              prev_csn = 1'b1;
  logic              prev_dc = 1'b0;
  int                frames = 0;
  int                dc_err = 0;

  always @(negedge clk_in) begin
    ent_t tmp;
    if (reset) begin
      mon_bits = 0;
    end else begin
      if (bus.oled_csn === 1'b0 && bus.oled_clk === 1'b1 && prev_sck === 1'b0) begin
        if (mon_bits == 0) mon_dc = bus.oled_dc;
        else if (bus.oled_dc !== mon_dc) dc_err++;
        mon_sh = {mon_sh[DATA_W-2:0], bus.oled_mosi};
        mon_bits++;
        if (mon_bits == DATA_W) begin
          rx_q.push_back({1'b0, mon_dc, mon_sh});
          $display("rx   data=%h dc=%0d", mon_sh, mon_dc);
          mon_bits = 0;
        end
      end
      if (bus.oled_csn === 1'b1 && prev_csn === 1'b0) begin
        mon_bits = 0;
        if (rx_q.size() > 0) begin
          tmp = rx_q[rx_q.size()-1];
          tmp[DATA_W+1] = 1'b1;
          rx_q[rx_q.size()-1] = tmp;
        end
      end
      if (bus.oled_csn === 1'b0 && prev_csn === 1'b1) frames++;
      if (bus.oled_clk === 1'b1 && prev_sck === 1'b1 && bus.oled_dc !== prev_dc) dc_err++;
    end
    prev_sck = bus.oled_clk;
    prev_csn = bus.oled_csn;
    prev_dc  = bus.oled_dc;
  end

  // ---------------- stimulus helpers ------------------------------------
  // Called at a falling edge; returns one cycle later with the push sampled.
  task automatic push_word(input logic [DATA_W-1:0] d, input logic dc, input logic last);
    bus.push      = 1'b1;
    bus.push_data = d;
    bus.push_dc   = dc;
    bus.push_last = last;
    $display("push data=%h dc=%0d last=%0d", d, dc, last);
    @(negedge clk_in);
    bus.push = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    int n = 0;
    while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    ok = (n < budget);
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    n_checks++; if (bus.oled_csn !== 1'b1) $display("FAIL reset_csn: got %b want 1", bus.oled_csn); else n_pass++;
    n_checks++; if (bus.oled_clk !== 1'b0) $display("FAIL reset_sck: got %b want 0", bus.oled_clk); else n_pass++;
    n_checks++; if (bus.oled_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", bus.oled_mosi); else n_pass++;
    n_checks++; if (bus.oled_dc !== 1'b0) $display("FAIL reset_dc: got %b want 0", bus.oled_dc); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
    n_checks++; if (bus.level !== LVL_W'(0)) $display("FAIL reset_level: got %0d want 0", bus.level); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else n_pass++;
`ifdef OLED_SPI_TX_STATS_EN
    n_checks++; if (tx_count !== 16'd0) $display("FAIL reset_tx_count: got %0d want 0", tx_count); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop_count: got %0d want 0", drop_count); else n_pass++;
`endif
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single();
    int lat, low, hi, f0, e0;
    rx_q.delete();
    f0 = frames;
    e0 = dc_err;
    push_word(8'hAE, 1'b0, 1'b1);
    lat = 0;
    while (bus.oled_csn !== 1'b0 && lat < 20) begin @(negedge clk_in); lat++; end
    n_checks++; if (lat != 1) $display("FAIL single_cs_latency: got %0d cycles want 1", lat); else n_pass++;
    low = 0;
    while (bus.oled_csn === 1'b0 && low < 500) begin @(negedge clk_in); low++; end
    n_checks++; if (low != WORD_CYC) $display("FAIL single_cs_low: got %0d cycles want %0d", low, WORD_CYC); else n_pass++;
    // After CS rises: one completion cycle plus CS_GAP gap cycles before idle.
    hi = 0;
    while (bus.busy === 1'b1 && hi < 100) begin @(negedge clk_in); hi++; end
    n_checks++; if (hi != CS_GAP + 1) $display("FAIL single_gap: got %0d busy cycles after CS rise want %0d", hi, CS_GAP + 1); else n_pass++;
    n_checks++; if (rx_q.size() != 1) $display("FAIL single_count: got %0d words want 1", rx_q.size());
    else begin
      n_pass++;
      n_checks++; if (rx_q[0] !== {1'b1, 1'b0, 8'hAE}) $display("FAIL single_word: got %h want %h", rx_q[0], {1'b1, 1'b0, 8'hAE}); else n_pass++;
    end
    n_checks++; if (frames - f0 != 1) $display("FAIL single_frames: got %0d want 1", frames - f0); else n_pass++;
    n_checks++; if (dc_err != e0) $display("FAIL single_dc_stable: got %0d dc glitches want 0", dc_err - e0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f0, e0;
    logic ok;
    rx_q.delete();
    exp_q.delete();
    f0 = frames;
    e0 = dc_err;
    push_word(8'h81, 1'b0, 1'b0); exp_q.push_back({1'b0, 1'b0, 8'h81});
    push_word(8'h7F, 1'b0, 1'b0); exp_q.push_back({1'b0, 1'b0, 8'h7F});
    push_word(8'hA5, 1'b1, 1'b1); exp_q.push_back({1'b1, 1'b1, 8'hA5});
    wait_idle(1000, ok);
    n_checks++; if (!ok) $display("FAIL burst_timeout: busy=%b empty=%b want idle", bus.busy, bus.empty); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL burst_count: got %0d words want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL burst_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (frames - f0 != 1) $display("FAIL burst_frames: got %0d CS frames want 1", frames - f0); else n_pass++;
    n_checks++; if (dc_err != e0) $display("FAIL burst_dc_stable: got %0d dc glitches want 0", dc_err - e0); else n_pass++;
  endtask

  task automatic test_starvation();
    int f0;
    logic ok;
    rx_q.delete();
    exp_q.delete();
    f0 = frames;
    push_word(8'h20, 1'b0, 1'b0); exp_q.push_back({1'b0, 1'b0, 8'h20});
    repeat (100) @(negedge clk_in);
    n_checks++; if (bus.oled_csn !== 1'b0) $display("FAIL hold_csn: got %b want 0", bus.oled_csn); else n_pass++;
    n_checks++; if (bus.oled_clk !== 1'b0) $display("FAIL hold_sck: got %b want 0", bus.oled_clk); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL hold_busy: got %b want 1", bus.busy); else n_pass++;
    push_word(8'h00, 1'b1, 1'b1); exp_q.push_back({1'b1, 1'b1, 8'h00});
    wait_idle(1000, ok);
    n_checks++; if (!ok) $display("FAIL hold_timeout: busy=%b empty=%b want idle", bus.busy, bus.empty); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL hold_count: got %0d words want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL hold_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (frames - f0 != 1) $display("FAIL hold_frames: got %0d CS frames want 1", frames - f0); else n_pass++;
  endtask

  task automatic test_overflow();
    int   f0, n_push, n_acc;
    logic ok;
    test_reset();
    f0 = frames;
    // A word takes far longer than the burst, so only the first entry is
    // pulled into the serialiser before the FIFO fills: DEPTH+1 accepted.
    n_push = DEPTH + 3;
    n_acc  = DEPTH + 1;
    for (int i = 0; i < n_push; i++) begin
      push_word(DATA_W'(i + 1), i[0], 1'b1);
      if (i < n_acc) exp_q.push_back({1'b1, i[0], DATA_W'(i + 1)});
    end
    n_checks++; if (bus.level !== LVL_W'(DEPTH)) $display("FAIL ovf_level: got %0d want %0d", bus.level, DEPTH); else n_pass++;
    n_checks++; if (bus.full !== 1'b1) $display("FAIL ovf_full: got %b want 1", bus.full); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.overflow); else n_pass++;
    wait_idle(n_acc * (WORD_CYC + CS_GAP + 10), ok);
    n_checks++; if (!ok) $display("FAIL ovf_timeout: busy=%b empty=%b want idle", bus.busy, bus.empty); else n_pass++;
    n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d words want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL ovf_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (frames - f0 != n_acc) $display("FAIL ovf_frames: got %0d want %0d", frames - f0, n_acc); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL ovf_drained_full: got %b want 0", bus.full); else n_pass++;
`ifdef OLED_SPI_TX_STATS_EN
    n_checks++; if (tx_count !== 16'(n_acc)) $display("FAIL stats_tx_count: got %0d want %0d", tx_count, n_acc); else n_pass++;
    n_checks++; if (drop_count !== 8'(n_push - n_acc)) $display("FAIL stats_drop_count: got %0d want %0d", drop_count, n_push - n_acc); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_word();
    int   rises, n;
    logic ps;
    logic ok;
    push_word(8'hC3, 1'b1, 1'b1);
    rises = 0;
    n     = 0;
    ps    = 1'b0;
    while (rises < 3 && n < 500) begin
      @(negedge clk_in);
      if (bus.oled_clk === 1'b1 && ps === 1'b0) rises++;
      ps = bus.oled_clk;
      n++;
    end
    n_checks++; if (rises != 3) $display("FAIL midrst_sck_rises: got %0d want 3", rises); else n_pass++;
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    n_checks++; if (bus.oled_csn !== 1'b1) $display("FAIL midrst_csn: got %b want 1", bus.oled_csn); else n_pass++;
    n_checks++; if (bus.oled_clk !== 1'b0) $display("FAIL midrst_sck: got %b want 0", bus.oled_clk); else n_pass++;
    n_checks++; if (bus.level !== LVL_W'(0)) $display("FAIL midrst_level: got %0d want 0", bus.level); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.oled_mosi !== 1'b0) $display("FAIL midrst_mosi: got %b want 0", bus.oled_mosi); else n_pass++;
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    rx_q.delete();
    exp_q.delete();
    push_word(8'h3C, 1'b0, 1'b1); exp_q.push_back({1'b1, 1'b0, 8'h3C});
    wait_idle(1000, ok);
    n_checks++; if (!ok) $display("FAIL midrst_timeout: busy=%b empty=%b want idle", bus.busy, bus.empty); else n_pass++;
    n_checks++; if (rx_q.size() != 1) $display("FAIL midrst_count: got %0d words want 1", rx_q.size());
    else begin
      n_pass++;
      n_checks++; if (rx_q[0] !== exp_q[0]) $display("FAIL midrst_word: got %h want %h", rx_q[0], exp_q[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int   f0, e0, nfr, nw, gap;
    logic [DATA_W-1:0] d;
    logic dc, last, ok;
    for (int b = 0; b < 4; b++) begin
      rx_q.delete();
      exp_q.delete();
      f0  = frames;
      e0  = dc_err;
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        nw = $urandom_range(1, 4);
        for (int w = 0; w < nw; w++) begin
          gap = ($urandom_range(0, 5) == 0) ? 80 : $urandom_range(0, 3);
          repeat (gap) @(negedge clk_in);
          d    = DATA_W'($urandom);
          dc   = 1'($urandom_range(0, 1));
          last = (w == nw - 1);
          push_word(d, dc, last);
          exp_q.push_back({last, dc, d});
        end
      end
      wait_idle(4000, ok);
      n_checks++; if (!ok) $display("FAIL rand%0d_timeout: busy=%b empty=%b want idle", b, bus.busy, bus.empty); else n_pass++;
      n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d words want %0d", b, rx_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL rand%0d_word%0d: got %h want %h", b, i, rx_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if (frames - f0 != nfr) $display("FAIL rand%0d_frames: got %0d want %0d", b, frames - f0, nfr); else n_pass++;
      n_checks++; if (dc_err != e0) $display("FAIL rand%0d_dc_stable: got %0d dc glitches want 0", b, dc_err - e0); else n_pass++;
      n_checks++; if (bus.overflow !== 1'b0) $display("FAIL rand%0d_overflow: got %b want 0", b, bus.overflow); else n_pass++;
    end
  endtask

  // ---------------- sequence ----------------------------------------------
  initial begin
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.push_dc   = 1'b0;
    bus.push_last = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_starvation();
    test_random();
    test_reset_mid_word();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
